// File: rtl/intr_ctrl.sv
// intr_ctrl: vectored interrupt controller sitting between peripheral request
// lines and the CPU intr/inta handshake. Rising edges on irq latch into PEND,
// MASK gates them, the lowest-index eligible request is presented to the CPU
// and then held in service until software writes EOI.
module intr_ctrl #(
  parameter int VW = 3
) (
  input  logic                clk_i,
  input  logic                clrn_i,
  input  logic [(2**VW)-1:0]  irq_i,
  output logic                intr_o,
  input  logic                inta_i,
  output logic [VW-1:0]       vector_o,
  input  logic [1:0]          addr_i,
  input  logic                we_i,
  input  logic [31:0]         wdata_i,
  output logic [31:0]         rdata_o
);

  localparam int NIRQ = 2**VW;

  localparam logic [1:0] ADDR_MASK = 2'd0;
  localparam logic [1:0] ADDR_PEND = 2'd1;
  localparam logic [1:0] ADDR_STAT = 2'd2;
  localparam logic [1:0] ADDR_EOI  = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    SERV = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              intr_q, intr_d;
  logic [VW-1:0]     vector_q, vector_d;
  logic              active_q, active_d;
  logic [NIRQ-1:0]   mask_q, mask_d;
  logic [NIRQ-1:0]   pend_q, pend_d;
  logic [NIRQ-1:0]   irq_q;
  logic              armed_q;

  logic [NIRQ-1:0]   edges;
  logic [NIRQ-1:0]   eligible;
  logic [VW-1:0]     winner;
  logic [NIRQ-1:0]   ackClr;
  logic [NIRQ-1:0]   pendWrClr;
  logic              eoiWr;
  logic              unusedWdata;

  // The first clock after reset only primes irq_q, so a line that was already
  // high while reset was asserted is not mistaken for a fresh rising edge.
  assign edges     = irq_i & ~irq_q & {NIRQ{armed_q}};
  assign eligible  = pend_q & mask_q;
  assign pendWrClr = (we_i && addr_i == ADDR_PEND) ? wdata_i[NIRQ-1:0] : '0;
  assign eoiWr     = we_i && (addr_i == ADDR_EOI);
  assign unusedWdata = ^wdata_i[31:NIRQ];

  // Fixed priority: scan from the top down so the lowest eligible index wins.
  always_comb begin
    winner = '0;
    for (int i = NIRQ - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        winner = VW'(i);
      end
    end
  end

  // Handshake FSM: raise intr, latch the winner on inta, wait for EOI.
  always_comb begin
    state_d  = state_q;
    intr_d   = intr_q;
    vector_d = vector_q;
    active_d = active_q;
    ackClr   = '0;
    case (state_q)
      IDLE: begin
        if (eligible != '0) begin
          state_d = REQ;
          intr_d  = 1'b1;
        end
      end
      REQ: begin
        if (inta_i && eligible != '0) begin
          state_d  = SERV;
          intr_d   = 1'b0;
          vector_d = winner;
          active_d = 1'b1;
          ackClr   = NIRQ'(1) << winner;
        end else if (eligible == '0) begin
          state_d = IDLE;
          intr_d  = 1'b0;
        end
      end
      SERV: begin
        intr_d = 1'b0;
        if (eoiWr) begin
          state_d  = IDLE;
          active_d = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        intr_d  = 1'b0;
      end
    endcase
  end

  // A new edge always re-sets its pending bit, even against a same-cycle
  // software clear or acknowledge of that bit.
  always_comb begin
    mask_d = mask_q;
    if (we_i && addr_i == ADDR_MASK) begin
      mask_d = wdata_i[NIRQ-1:0];
    end
    pend_d = (pend_q & ~(pendWrClr | ackClr)) | edges;
  end

  // Handshake state registers.
  always_ff @(posedge clk_i or negedge clrn_i) begin
    if (!clrn_i) begin
      state_q  <= IDLE;
      intr_q   <= 1'b0;
      vector_q <= '0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      intr_q   <= intr_d;
      vector_q <= vector_d;
      active_q <= active_d;
    end
  end

  // Software-visible MASK/PEND and the irq edge-detect history.
  always_ff @(posedge clk_i or negedge clrn_i) begin
    if (!clrn_i) begin
      mask_q  <= '0;
      pend_q  <= '0;
      irq_q   <= '0;
      armed_q <= 1'b0;
    end else begin
      mask_q  <= mask_d;
      pend_q  <= pend_d;
      irq_q   <= irq_i;
      armed_q <= 1'b1;
    end
  end

  // Register read mux; combinational so a CPU load completes in one cycle.
  always_comb begin
    rdata_o = '0;
    case (addr_i)
      ADDR_MASK: rdata_o[NIRQ-1:0] = mask_q;
      ADDR_PEND: rdata_o[NIRQ-1:0] = pend_q;
      ADDR_STAT: begin
        rdata_o[31]     = active_q;
        rdata_o[VW-1:0] = vector_q;
      end
      default: rdata_o = '0;
    endcase
  end

  assign intr_o   = intr_q;
  assign vector_o = vector_q;

endmodule

// File: tb/tb_intr_ctrl.sv
// tb_intr_ctrl: directed bench for intr_ctrl. Stimulus pushes hand-computed
// expectations into a scoreboard queue; a separate monitor pops and compares.
module tb_intr_ctrl;

  localparam int VW = 3;

  localparam int K_INTR = 0;
  localparam int K_VEC  = 1;
  localparam int K_REG  = 2;

  typedef struct {
    int          kind;
    logic [31:0] exp;
    string       name;
  } item_t;

  logic        clk = 1'b0;
  logic        clrn;
  logic [7:0]  irq;
  logic        intr;
  logic        inta;
  logic [2:0]  vector;
  logic [1:0]  addr;
  logic        we;
  logic [31:0] wdata;
  logic [31:0] rdata;

  item_t scoreQ[$];
  event  sampleEv;
  int    checks = 0;
  int    fails  = 0;

  intr_ctrl #(.VW(VW)) dut (
    .clk_i    (clk),
    .clrn_i   (clrn),
    .irq_i    (irq),
    .intr_o   (intr),
    .inta_i   (inta),
    .vector_o (vector),
    .addr_i   (addr),
    .we_i     (we),
    .wdata_i  (wdata),
    .rdata_o  (rdata)
  );

  // 20 ns clock leaves room for several combinational checks per cycle.
  always #10 clk = ~clk;

  // Monitor: whenever stimulus posts expectations, compare against the DUT.
  initial begin
    item_t       it;
    logic [31:0] act;
    forever begin
      @(sampleEv);
      while (scoreQ.size() > 0) begin
        it = scoreQ.pop_front();
        case (it.kind)
          K_INTR:  act = {31'b0, intr};
          K_VEC:   act = {29'b0, vector};
          default: act = rdata;
        endcase
        checks++;
        if (act !== it.exp) begin
          fails++;
          $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", it.name, act, it.exp);
        end
      end
    end
  end

  // Hard stop in case the sequence ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Drive one cycle of inputs, let a rising edge consume them, then settle.
  task automatic applyStimulus(input logic [7:0] irqV, input logic intaV,
                               input logic weV, input logic [1:0] aV,
                               input logic [31:0] dV);
    irq   = irqV;
    inta  = intaV;
    we    = weV;
    addr  = aV;
    wdata = dV;
    @(posedge clk);
    #1;
    inta  = 1'b0;
    we    = 1'b0;
    wdata = '0;
  endtask

  // Post one expectation and hand it to the monitor.
  task automatic checkOutput(input int kind, input logic [1:0] a,
                             input logic [31:0] exp, input string name);
    item_t it;
    if (kind == K_REG) addr = a;
    #1;
    it.kind = kind;
    it.exp  = exp;
    it.name = name;
    scoreQ.push_back(it);
    -> sampleEv;
    #1;
    if (scoreQ.size() != 0) begin
      $display("[TB] FAIL %s: monitor did not consume expectation", name);
      $fatal(1, "[TB] monitor stalled");
    end
  endtask

  task automatic chkIntr(input logic e, input string name);
    checkOutput(K_INTR, 2'd0, {31'b0, e}, name);
  endtask

  task automatic chkVec(input logic [2:0] e, input string name);
    checkOutput(K_VEC, 2'd0, {29'b0, e}, name);
  endtask

  task automatic chkReg(input logic [1:0] a, input logic [31:0] e, input string name);
    checkOutput(K_REG, a, e, name);
  endtask

  // Directed sequence.
  initial begin
    clrn  = 1'b1;
    irq   = 8'hFF;
    inta  = 1'b0;
    we    = 1'b0;
    addr  = 2'd0;
    wdata = '0;
    #5 clrn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chkIntr(1'b0, "rst_intr");
    chkVec(3'd0, "rst_vector");
    chkReg(2'd0, 32'h0, "rst_mask");
    chkReg(2'd1, 32'h0, "rst_pend");
    chkReg(2'd2, 32'h0, "rst_stat");
    clrn = 1'b1;
    applyStimulus(8'hFF, 0, 0, 2'd0, 0);
    applyStimulus(8'hFF, 0, 0, 2'd0, 0);
    chkReg(2'd1, 32'h0, "rst_release_no_edge");
    chkIntr(1'b0, "rst_release_intr");
    applyStimulus(8'h00, 0, 0, 2'd0, 0);

    // Single request on irq[5].
    applyStimulus(8'h00, 0, 1, 2'd0, 32'h20);
    applyStimulus(8'h20, 0, 0, 2'd0, 0);
    chkIntr(1'b0, "single_lat1");
    applyStimulus(8'h00, 0, 0, 2'd0, 0);
    chkIntr(1'b1, "single_lat2");
    applyStimulus(8'h00, 1, 0, 2'd0, 0);
    chkIntr(1'b0, "single_ack_intr");
    chkVec(3'd5, "single_ack_vec");
    chkReg(2'd2, 32'h8000_0005, "single_stat");
    chkReg(2'd1, 32'h0, "single_pend");
    chkReg(2'd3, 32'h0, "eoi_reads_zero");
    applyStimulus(8'h00, 0, 1, 2'd3, 32'hDEAD_BEEF);
    chkReg(2'd2, 32'h0000_0005, "single_eoi_stat");
    chkIntr(1'b0, "single_eoi_intr");
    applyStimulus(8'h00, 0, 0, 2'd0, 0);
    chkIntr(1'b0, "single_idle_intr");

    // Priority between irq[6] and irq[2].
    applyStimulus(8'h00, 0, 1, 2'd0, 32'hFF);
    applyStimulus(8'h44, 0, 0, 2'd0, 0);
    applyStimulus(8'h00, 0, 0, 2'd0, 0);
    chkIntr(1'b1, "prio_intr");
    applyStimulus(8'h00, 1, 0, 2'd0, 0);
    chkVec(3'd2, "prio_vec_first");
    chkReg(2'd1, 32'h40, "prio_pend_left");
    chkIntr(1'b0, "prio_ack_intr");
    applyStimulus(8'h00, 0, 1, 2'd3, 0);
    chkIntr(1'b0, "prio_eoi_edge");
    applyStimulus(8'h00, 0, 0, 2'd0, 0);
    chkIntr(1'b1, "prio_eoi_next");
    applyStimulus(8'h00, 1, 0, 2'd0, 0);
    chkVec(3'd6, "prio_vec_second");
    chkReg(2'd2, 32'h8000_0006, "prio_stat_second");
    chkReg(2'd1, 32'h0, "prio_pend_empty");
    applyStimulus(8'h00, 0, 1, 2'd3, 0);
    applyStimulus(8'h00, 0, 0, 2'd0, 0);
    chkIntr(1'b0, "prio_done_intr");

    // Masked pending request released by a MASK write.
    applyStimulus(8'h00, 0, 1, 2'd0, 32'h0);
    applyStimulus(8'h08, 0, 0, 2'd0, 0);
    applyStimulus(8'h00, 0, 0, 2'd0, 0);
    chkReg(2'd1, 32'h08, "masked_pend");
    chkIntr(1'b0, "masked_intr");
    applyStimulus(8'h00, 0, 0, 2'd0, 0);
    chkIntr(1'b0, "masked_intr_hold");
    applyStimulus(8'h00, 0, 1, 2'd0, 32'h08);
    chkIntr(1'b0, "unmask_edge_w");
    applyStimulus(8'h00, 0, 0, 2'd0, 0);
    chkIntr(1'b1, "unmask_edge_w1");
    applyStimulus(8'h00, 1, 0, 2'd0, 0);
    chkVec(3'd3, "unmask_vec");
    applyStimulus(8'h00, 0, 1, 2'd3, 0);

    // Withdrawal while in REQ.
    applyStimulus(8'h00, 0, 1, 2'd0, 32'h02);
    applyStimulus(8'h02, 0, 0, 2'd0, 0);
    applyStimulus(8'h00, 0, 0, 2'd0, 0);
    chkIntr(1'b1, "wd_req_intr");
    applyStimulus(8'h00, 0, 1, 2'd1, 32'h02);
    chkIntr(1'b1, "wd_clear_edge");
    applyStimulus(8'h00, 0, 0, 2'd0, 0);
    chkIntr(1'b0, "wd_dropped");
    applyStimulus(8'h00, 1, 0, 2'd0, 0);
    chkIntr(1'b0, "wd_late_inta_intr");
    chkReg(2'd2, 32'h0000_0003, "wd_stat_inactive");
    chkReg(2'd1, 32'h0, "wd_pend");
    applyStimulus(8'h00, 0, 0, 2'd0, 0);
    chkIntr(1'b0, "wd_stays_idle");

    // Set versus software clear on irq[4].
    applyStimulus(8'h00, 0, 1, 2'd0, 32'h0);
    applyStimulus(8'h10, 0, 0, 2'd0, 0);
    applyStimulus(8'h10, 0, 1, 2'd1, 32'h10);
    chkReg(2'd1, 32'h0, "w1c_level_clears");
    applyStimulus(8'h00, 0, 0, 2'd0, 0);
    applyStimulus(8'h10, 0, 1, 2'd1, 32'h10);
    chkReg(2'd1, 32'h10, "set_beats_w1c");
    applyStimulus(8'h00, 0, 0, 2'd0, 0);

    // Set versus acknowledge on irq[4].
    applyStimulus(8'h00, 0, 1, 2'd0, 32'h10);
    chkReg(2'd1, 32'h10, "ack_setup_pend");
    applyStimulus(8'h00, 0, 0, 2'd0, 0);
    chkIntr(1'b1, "ack_setup_intr");
    applyStimulus(8'h10, 1, 0, 2'd0, 0);
    chkVec(3'd4, "set_ack_vec");
    chkIntr(1'b0, "set_ack_intr");
    chkReg(2'd1, 32'h10, "set_beats_ack");
    chkReg(2'd2, 32'h8000_0004, "set_ack_stat");

    // Edges during SERV only accumulate.
    applyStimulus(8'h21, 0, 0, 2'd0, 0);
    applyStimulus(8'h00, 0, 0, 2'd0, 0);
    chkReg(2'd1, 32'h31, "serv_accum_pend");
    chkIntr(1'b0, "serv_accum_intr");
    applyStimulus(8'h00, 0, 0, 2'd0, 0);
    chkIntr(1'b0, "serv_no_nest");
    chkReg(2'd0, 32'h10, "serv_mask");

    // Asynchronous reset mid-service clears everything before the next edge.
    clrn = 1'b0;
    #1;
    chkIntr(1'b0, "midrst_intr");
    chkVec(3'd0, "midrst_vec");
    chkReg(2'd0, 32'h0, "midrst_mask");
    chkReg(2'd1, 32'h0, "midrst_pend");
    chkReg(2'd2, 32'h0, "midrst_stat");
    @(posedge clk);
    #1;
    clrn = 1'b1;
    applyStimulus(8'h00, 0, 0, 2'd0, 0);
    applyStimulus(8'h00, 0, 0, 2'd0, 0);
    chkIntr(1'b0, "post_rst_intr");

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
